// File: rtl/ds_pkg.sv
// Shared definitions for the DownSample line sequencer: state encoding and
// the minimum frame geometry accepted on sof.
package ds_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_STREAM = 2'd2
   } ds_state_e;

   localparam int DS_MIN_DIM = 2;

endpackage

// File: rtl/ds_pos_cnt.sv
// Column/row position counter for one frame. Wraps the column at the latched
// line width and the row at the latched height, and reports terminal counts.
module ds_pos_cnt
   import ds_pkg::*;
#(
   parameter int AWIDTH = 11,
   parameter int HWIDTH = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,
   input  logic              i_adv,
   input  logic [AWIDTH-1:0] i_width,
   input  logic [HWIDTH-1:0] i_height,
   output logic [AWIDTH-1:0] o_col,
   output logic [HWIDTH-1:0] o_row,
   output logic              o_col_tc,
   output logic              o_row_tc
);

   logic [AWIDTH-1:0] r_col;
   logic [HWIDTH-1:0] r_row;
   logic              w_col_tc;
   logic              w_row_tc;

   assign w_col_tc = (r_col == i_width - AWIDTH'(1));
   assign w_row_tc = (r_row == i_height - HWIDTH'(1));

   // The final pixel of a frame wraps both counters back to the origin, so
   // an IDLE sequencer always reports position (0,0).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col <= '0;
         r_row <= '0;
      end else if (i_clr) begin
         r_col <= '0;
         r_row <= '0;
      end else if (i_adv) begin
         if (w_col_tc) begin
            r_col <= '0;
            r_row <= w_row_tc ? '0 : r_row + HWIDTH'(1);
         end else begin
            r_col <= r_col + AWIDTH'(1);
         end
      end
   end

   assign o_col    = r_col;
   assign o_row    = r_row;
   assign o_col_tc = w_col_tc;
   assign o_row_tc = w_row_tc;

endmodule

// File: rtl/ds_line_sched.sv
// Frame sequencer for the single-line SRAM buffer: pairs each pixel of row r
// with the same column of row r-1 and flags completed 2x2 decimation windows.
module ds_line_sched
   import ds_pkg::*;
#(
   parameter int AWIDTH = 11,
   parameter int HWIDTH = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clken,
   input  logic              sof,
   input  logic [AWIDTH-1:0] width,
   input  logic [HWIDTH-1:0] height,
   input  logic              valid_in,
   output logic              wr_en,
   output logic              rd_en,
   output logic [AWIDTH-1:0] line_width,
   output logic [AWIDTH-1:0] col,
   output logic [HWIDTH-1:0] row,
   output logic              win_valid,
   output logic              frame_done,
   output logic              busy,
   output logic              cfg_err,
   output logic [1:0]        dbg_state
);

   ds_state_e         r_state;
   ds_state_e         w_state_nxt;
   logic [AWIDTH-1:0] r_width;
   logic [HWIDTH-1:0] r_height;
   logic              r_win;
   logic              r_done;
   logic              r_cfg_err;

   logic              w_sof;
   logic              w_geom_ok;
   logic              w_busy;
   logic              w_accept;
   logic [AWIDTH-1:0] w_col;
   logic [HWIDTH-1:0] w_row;
   logic              w_col_tc;
   logic              w_row_tc;

   assign w_sof     = clken & sof;
   assign w_geom_ok = (width >= AWIDTH'(DS_MIN_DIM)) && !width[0] &&
                      (height >= HWIDTH'(DS_MIN_DIM)) && !height[0];
   assign w_busy    = (r_state != ST_IDLE);
   // Handshake: a pixel is taken when valid_in is high in an enabled cycle of
   // an active frame; there is no backpressure, and sof wins over the pixel.
   assign w_accept  = clken & valid_in & w_busy & ~sof;

   ds_pos_cnt #(
      .AWIDTH (AWIDTH),
      .HWIDTH (HWIDTH)
   ) u_pos_cnt (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_sof),
      .i_adv    (w_accept),
      .i_width  (r_width),
      .i_height (r_height),
      .o_col    (w_col),
      .o_row    (w_row),
      .o_col_tc (w_col_tc),
      .o_row_tc (w_row_tc)
   );

   always_comb begin
      w_state_nxt = r_state;
      if (w_sof) begin
         w_state_nxt = w_geom_ok ? ST_FILL : ST_IDLE;
      end else begin
         case (r_state)
            ST_FILL: begin
               if (w_accept && w_col_tc) w_state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
               if (w_accept && w_col_tc && w_row_tc) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else if (clken) begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_width   <= '0;
         r_height  <= '0;
         r_cfg_err <= 1'b0;
      end else if (w_sof) begin
         if (w_geom_ok) begin
            r_width   <= width;
            r_height  <= height;
            r_cfg_err <= 1'b0;
         end else begin
            r_cfg_err <= 1'b1;
         end
      end
   end

   // Window closes on the odd/odd pixel: its three partners are already in
   // the line buffer or the averaging datapath.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_win  <= 1'b0;
         r_done <= 1'b0;
      end else if (clken) begin
         r_win  <= w_accept & w_row[0] & w_col[0];
         r_done <= w_accept & (r_state == ST_STREAM) & w_col_tc & w_row_tc;
      end
   end

   assign wr_en      = w_accept;
   assign rd_en      = w_accept & (r_state == ST_STREAM);
   assign line_width = r_width;
   assign col        = w_col;
   assign row        = w_row;
   assign win_valid  = r_win;
   assign frame_done = r_done;
   assign busy       = w_busy;
   assign cfg_err    = r_cfg_err;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_ds_line_sched.sv
// Bench for ds_line_sched: a pixel-index frame model predicts every output
// each cycle; directed frames pin pulse counts to hand-computed literals.
module tb_ds_line_sched;

  localparam int AW = 11;
  localparam int HW = 11;

  // clock/reset block
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          clken, sof, valid_in;
  logic [AW-1:0] width;
  logic [HW-1:0] height;
  logic          wr_en, rd_en, win_valid, frame_done, busy, cfg_err;
  logic [AW-1:0] line_width, col;
  logic [HW-1:0] row;
  logic [1:0]    dbg_state;

  ds_line_sched #(.AWIDTH(AW), .HWIDTH(HW)) dut (
    .clk        (clk),
    .rst        (rst),
    .clken      (clken),
    .sof        (sof),
    .width      (width),
    .height     (height),
    .valid_in   (valid_in),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .line_width (line_width),
    .col        (col),
    .row        (row),
    .win_valid  (win_valid),
    .frame_done (frame_done),
    .busy       (busy),
    .cfg_err    (cfg_err),
    .dbg_state  (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // frame model: pixel index k within a W x H frame
  int m_busy, m_k, m_w, m_h, m_err, m_win, m_done, m_lw;
  // pulse tallies for literal pins
  int t_wr, t_rd, t_win, t_done;
  int prev_ce;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_k = 0; m_w = 0; m_h = 0;
    m_err = 0; m_win = 0; m_done = 0; m_lw = 0;
  endtask

  task automatic tally_clear();
    t_wr = 0; t_rd = 0; t_win = 0; t_done = 0;
  endtask

  task automatic check_outputs(input int e_wr, input int e_rd);
    int e_col, e_row, e_state;
    e_col   = m_busy ? (m_k % m_w) : 0;
    e_row   = m_busy ? (m_k / m_w) : 0;
    e_state = !m_busy ? 0 : ((m_k < m_w) ? 1 : 2);
    chk("wr_en", int'(wr_en), e_wr);
    chk("rd_en", int'(rd_en), e_rd);
    chk("col", int'(col), e_col);
    chk("row", int'(row), e_row);
    chk("busy", int'(busy), m_busy);
    chk("cfg_err", int'(cfg_err), m_err);
    chk("win_valid", int'(win_valid), m_win);
    chk("frame_done", int'(frame_done), m_done);
    chk("line_width", int'(line_width), m_lw);
    chk("state", int'(dbg_state), e_state);
  endtask

  // driver + compare for one clock: drive, check at negedge, advance model
  task automatic cycle(input int s, input int v, input int ce, input int w, input int h);
    int acc, ok, c, r;
    sof = 1'(s); valid_in = 1'(v); clken = 1'(ce);
    width = AW'(w); height = HW'(h);
    @(negedge clk);
    acc = (ce != 0 && v != 0 && m_busy != 0 && s == 0) ? 1 : 0;
    check_outputs(acc, (acc != 0 && m_k >= m_w) ? 1 : 0);
    t_wr += int'(wr_en);
    t_rd += int'(rd_en);
    if (prev_ce != 0) begin
      t_win  += int'(win_valid);
      t_done += int'(frame_done);
    end
    if (ce != 0) begin
      if (s != 0) begin
        ok = (w >= 2 && h >= 2 && w % 2 == 0 && h % 2 == 0) ? 1 : 0;
        m_win = 0; m_done = 0; m_k = 0;
        if (ok != 0) begin
          m_busy = 1; m_w = w; m_h = h; m_lw = w; m_err = 0;
        end else begin
          m_busy = 0; m_err = 1;
        end
      end else if (acc != 0) begin
        c = m_k % m_w;
        r = m_k / m_w;
        m_win  = (r % 2 == 1 && c % 2 == 1) ? 1 : 0;
        m_done = (m_k == m_w * m_h - 1) ? 1 : 0;
        m_k++;
        if (m_k == m_w * m_h) begin
          m_busy = 0; m_k = 0;
        end
      end else begin
        m_win = 0; m_done = 0;
      end
    end
    prev_ce = ce;
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    sof = 1'b0; valid_in = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs(0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    prev_ce = 0;
  endtask

  // mode 0: continuous pixels; mode 1: valid toggles, clken low every 3rd cycle
  task automatic run_frame(input int w, input int h, input int mode);
    int n;
    cycle(1, 0, 1, w, h);
    n = 0;
    while (m_busy != 0 && n < 400) begin
      if (mode == 0) cycle(0, 1, 1, w, h);
      else cycle(0, (n % 2 == 0) ? 1 : 0, (n % 3 != 2) ? 1 : 0, w, h);
      n++;
    end
    if (m_busy != 0) chk("frame_timeout", 1, 0);
    cycle(0, 0, 1, w, h);
    cycle(0, 0, 1, w, h);
  endtask

  initial begin
    rst = 1'b1; clken = 1'b0; sof = 1'b0; valid_in = 1'b0;
    width = '0; height = '0;
    prev_ce = 0;
    model_reset();
    tally_clear();
    @(posedge clk);
    #1;
    check_outputs(0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 4x4 continuous
    tally_clear();
    run_frame(4, 4, 0);
    chk("4x4_wr_count", t_wr, 16);
    chk("4x4_rd_count", t_rd, 12);
    chk("4x4_win_count", t_win, 4);
    chk("4x4_done_count", t_done, 1);

    // 4x4 with gaps and clock-enable holes
    tally_clear();
    run_frame(4, 4, 1);
    chk("gap_wr_count", t_wr, 16);
    chk("gap_rd_count", t_rd, 12);
    chk("gap_win_count", t_win, 4);
    chk("gap_done_count", t_done, 1);

    // bad geometry, then a good 4x2 frame
    tally_clear();
    cycle(1, 1, 1, 3, 4);
    cycle(0, 1, 1, 3, 4);
    chk("bad_w_cfg_err", int'(cfg_err), 1);
    cycle(1, 0, 1, 4, 1);
    cycle(0, 1, 1, 4, 1);
    chk("bad_h_busy", int'(busy), 0);
    chk("bad_wr_count", t_wr, 0);
    run_frame(4, 2, 0);
    chk("4x2_cfg_err", int'(cfg_err), 0);
    chk("4x2_win_count", t_win, 2);
    chk("4x2_done_count", t_done, 1);

    // abort at row 2 col 1
    tally_clear();
    cycle(1, 0, 1, 4, 4);
    for (int i = 0; i < 9; i++) cycle(0, 1, 1, 4, 4);
    chk("abort_pos_row", int'(row), 2);
    chk("abort_pos_col", int'(col), 1);
    run_frame(4, 4, 0);
    chk("abort_done_count", t_done, 1);
    chk("abort_rd_count", t_rd, 5 + 12);

    // async reset at row 1 col 2, then 4x2
    cycle(1, 0, 1, 4, 4);
    for (int i = 0; i < 6; i++) cycle(0, 1, 1, 4, 4);
    chk("rst_pos_col", int'(col), 2);
    async_reset();
    tally_clear();
    run_frame(4, 2, 0);
    chk("post_rst_win_count", t_win, 2);
    chk("post_rst_done_count", t_done, 1);

    // back-to-back 2x2 frames with no gap
    tally_clear();
    cycle(1, 0, 1, 2, 2);
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, 2, 2);
    cycle(1, 0, 1, 2, 2);
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, 2, 2);
    cycle(0, 0, 1, 2, 2);
    chk("b2b_win_count", t_win, 2);
    chk("b2b_done_count", t_done, 2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int s;
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
      end else begin
        s = ($urandom_range(0, 59) == 0 ||
             (m_busy == 0 && $urandom_range(0, 4) == 0)) ? 1 : 0;
        cycle(s, ($urandom_range(0, 3) != 0) ? 1 : 0,
              ($urandom_range(0, 4) != 0) ? 1 : 0,
              $urandom_range(0, 8), $urandom_range(0, 6));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ds_line_sched.md
# ds_line_sched

Frame-level sequencer for the DownSample single-line SRAM buffer and its address counter. It tracks pixel column/row, and generates the per-pixel SRAM read/write enables so that each pixel of row r is paired with the same column of row r−1. It flags which pairs form a 2×2 decimation window and pulses frame completion. It sits between the pixel stream input and the SRAM address controller / 2×2 averaging datapath.

## Interface
Parameters:
- AWIDTH, 11, column counter / line width bits (matches SRAM address width)
- HWIDTH, 11, row counter / frame height bits

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- clken  in  1  global clock enable; low freezes all state, outputs held
- sof  in  1  start-of-frame pulse; latches geometry, starts frame
- width  in  AWIDTH  pixels per line, sampled on sof
- height  in  HWIDTH  lines per frame, sampled on sof
- valid_in  in  1  input pixel valid this cycle
- wr_en  out  1  SRAM write enable (combinational)
- rd_en  out  1  SRAM read enable (combinational)
- line_width  out  AWIDTH  latched width, drives address-counter wrap
- col  out  AWIDTH  column of current pixel
- row  out  HWIDTH  row of current pixel
- win_valid  out  1  registered: previous accepted pixel closed a 2×2 window
- frame_done  out  1  registered one-cycle pulse after last pixel
- busy  out  1  high in FILL or STREAM
- cfg_err  out  1  sticky: sof rejected for bad geometry; cleared by next accepted sof

## Operation
- Accept = clken & valid_in & state∈{FILL,STREAM}.
- States: IDLE → FILL → STREAM → IDLE.
  - IDLE: enables low; on clken & sof with width≥2, height≥2, both even: latch width/height, col=row=0, go FILL, clear cfg_err. Otherwise set cfg_err, stay IDLE.
  - FILL (row 0): wr_en=accept, rd_en=0. On accept at col=width−1: col←0, row←1, go STREAM.
  - STREAM (rows 1..height−1): wr_en=rd_en=accept. Column wraps at width−1; row increments on wrap. Accepting col=width−1, row=height−1 → IDLE, frame_done next cycle.
- Window: win_valid←accept & row[0] & col[0] (odd row, odd column), else 0.
- sof while busy (clken high): abort current frame. Treat exactly as sof in IDLE, including geometry check; a rejected sof returns to IDLE. A valid_in in the same cycle is ignored. No frame_done for the aborted frame.
- sof has priority over valid_in; valid_in in IDLE ignored.
- Counters reach exactly width−1 / height−1, never wrap past latched geometry.

## Timing
- Reset values: state IDLE, col=0, row=0, line_width=0, win_valid=0, frame_done=0, busy=0, cfg_err=0; wr_en=rd_en=0 (IDLE).
- wr_en/rd_en: same-cycle combinational from valid_in/clken/state. SRAM address controller advances on the same edge as col.
- win_valid, frame_done: 1-cycle latency after the accepting edge. Held (not re-pulsed) while clken low.
- Reset mid-frame: immediate return to IDLE; SRAM contents ignored, next frame refills.
- Throughput: one pixel per clken cycle, no bubbles between rows or frames. sof may arrive the cycle after the last pixel.

## Structure
- Shared package ds_pkg: state encoding (IDLE=2'd0, FILL=2'd1, STREAM=2'd2), minimum geometry constant DS_MIN_DIM=2.
- One sub-module natural: ds_pos_cnt (col/row counter with wrap at latched width/height, terminal-count outputs). FSM and enable logic live in ds_line_sched.

## Test plan
- width=4, height=4, continuous valid_in: wr_en high 16 cycles; rd_en low first 4, high last 12. win_valid pulses after pixels (1,1),(1,3),(3,1),(3,3) = 4 pulses. frame_done one cycle after 16th pixel.
- Same frame with valid_in toggling 1/0 and clken low every 3rd cycle: identical enable counts and win_valid sequence; no state change while clken low.
- sof with width=3 or height=1: cfg_err=1, busy=0, no enables. Then valid sof width=4/height=2: cfg_err clears, 8-pixel frame completes.
- sof at row 2 col 1 of a 4×4 frame: restarts row=col=0 in FILL, rd_en low for next 4 pixels, no frame_done for aborted frame.
- rst asserted at row 1 col 2: all outputs zero asynchronously. Next sof, 4×2 frame: 2 win_valid, frame_done.
- Back-to-back frames: sof the cycle after frame_done's source pixel, width=2/height=2: both frames produce 1 win_valid each and 2 frame_done pulses.
